// File: rtl/uart_frac_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_frac_baud_gen
//
// Two-channel (RX, TX) UART baud generator with a fractional divisor
// {int, frac}. The integer part is the base period in clocks. The fraction,
// in units of 1/2^FRAC_W clock, builds up in an accumulator. Its carry lengthens
// the following period by one clock. The mean tick period is therefore
// int + frac/2^FRAC_W clocks.
//
// Each channel produces an oversample tick (x_tick) and a per-bit tick
// (x_bit_tick) once every SAMPLE_RATE oversample ticks. On start_rx, RX bit
// ticks are phased to fall at bit centres. On start_tx, TX bit ticks are
// phased to fall at bit boundaries.
//
// A div_wr updates only the shadow divisor. Each channel copies the shadow into
// its active divisor at a period boundary (terminal count or start), so a
// period never changes length while it is running.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high
//   enable       1 = channels count, 0 = hold state and suppress ticks
//   div_wr       strobe: load div_int/div_frac into the shadow divisor
//   div_int      integer part of the period (legal >= 2)
//   div_frac     fractional part of the period
//   div_err      1-cycle pulse: div_wr rejected because div_int < 2
//   start_rx     realign the RX channel (start-bit edge)
//   start_tx     realign the TX channel (frame start)
//   rx_tick      RX oversample tick
//   rx_bit_tick  RX mid-bit tick, coincides with an rx_tick
//   tx_tick      TX oversample tick
//   tx_bit_tick  TX bit-boundary tick, coincides with a tx_tick
// -----------------------------------------------------------------------------
module uart_frac_baud_gen #(
    parameter int unsigned     CLK_HZ      = 25000000,
    parameter int unsigned     BAUD_RATE   = 9600,
    parameter int unsigned     SAMPLE_RATE = 16,
    parameter int unsigned     INT_W       = 16,
    parameter int unsigned     FRAC_W      = 4,
    parameter longint unsigned DEF_DIV     = (64'(CLK_HZ) << FRAC_W) / 64'(BAUD_RATE * SAMPLE_RATE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              div_wr,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              div_err,
    input  logic              start_rx,
    input  logic              start_tx,
    output logic              rx_tick,
    output logic              rx_bit_tick,
    output logic              tx_tick,
    output logic              tx_bit_tick
);

    localparam int unsigned DIV_W = INT_W + FRAC_W;
    localparam int unsigned SUB_W = (SAMPLE_RATE > 2) ? $clog2(SAMPLE_RATE) : 1;

    localparam logic [DIV_W-1:0]  DEF_DIV_V  = DEF_DIV[DIV_W-1:0];
    localparam logic [INT_W-1:0]  DEF_INT    = DEF_DIV_V[DIV_W-1:FRAC_W];
    localparam logic [FRAC_W-1:0] DEF_FRAC   = DEF_DIV_V[FRAC_W-1:0];
    localparam logic [INT_W:0]    PERIOD_ONE = (INT_W+1)'(1);

    // ------------------------------------------------------------------
    // Shadow divisor shared by both channels
    // ------------------------------------------------------------------
    logic [INT_W-1:0]  shadow_int_reg;
    logic [FRAC_W-1:0] shadow_frac_reg;
    logic              div_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_int_reg  <= DEF_INT;
            shadow_frac_reg <= DEF_FRAC;
            div_err_reg     <= 1'b0;
        end else begin
            div_err_reg <= 1'b0;
            if (div_wr) begin
                if (div_int >= INT_W'(2)) begin
                    shadow_int_reg  <= div_int;
                    shadow_frac_reg <= div_frac;
                end else begin
                    div_err_reg <= 1'b1;
                end
            end
        end
    end

    assign div_err = div_err_reg;

    // ------------------------------------------------------------------
    // Channels: index 0 = RX, index 1 = TX
    // ------------------------------------------------------------------
    logic [1:0] start_vec;
    logic [1:0] tick_vec;
    logic [1:0] bit_tick_vec;

    assign start_vec = {start_tx, start_rx};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            // RX presets the sub-counter half a bit ahead so that its bit tick
            // falls with oversample tick SAMPLE_RATE/2 (the bit centre).
            localparam logic [SUB_W-1:0] SUB_START =
                (gi == 0) ? SUB_W'(SAMPLE_RATE / 2) : '0;

            logic [INT_W-1:0]  cnt_reg;
            logic [FRAC_W-1:0] acc_reg;
            logic              ext_reg;
            logic [INT_W-1:0]  act_int_reg;
            logic [FRAC_W-1:0] act_frac_reg;
            logic [SUB_W-1:0]  sub_reg;
            logic              tick_reg;
            logic              bit_tick_reg;

            logic [INT_W:0]    period_last;
            logic              terminal;
            logic [FRAC_W:0]   acc_sum;
            logic              sub_last;

            // Last count of this period is act.int + ext - 1. The computation is
            // one bit wider than cnt, so int = 2^INT_W-1 with ext = 1 does not wrap.
            assign period_last = {1'b0, act_int_reg} + {{INT_W{1'b0}}, ext_reg} - PERIOD_ONE;
            assign terminal    = ({1'b0, cnt_reg} == period_last);
            assign acc_sum     = {1'b0, acc_reg} + {1'b0, act_frac_reg};
            assign sub_last    = (sub_reg == SUB_W'(SAMPLE_RATE - 1));

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg      <= '0;
                    acc_reg      <= '0;
                    ext_reg      <= 1'b0;
                    act_int_reg  <= DEF_INT;
                    act_frac_reg <= DEF_FRAC;
                    sub_reg      <= '0;
                    tick_reg     <= 1'b0;
                    bit_tick_reg <= 1'b0;
                end else if (start_vec[gi]) begin
                    // Realign: a terminal count on this edge is discarded.
                    cnt_reg      <= '0;
                    acc_reg      <= '0;
                    ext_reg      <= 1'b0;
                    act_int_reg  <= shadow_int_reg;
                    act_frac_reg <= shadow_frac_reg;
                    sub_reg      <= SUB_START;
                    tick_reg     <= 1'b0;
                    bit_tick_reg <= 1'b0;
                end else if (!enable) begin
                    tick_reg     <= 1'b0;
                    bit_tick_reg <= 1'b0;
                end else if (terminal) begin
                    cnt_reg             <= '0;
                    tick_reg            <= 1'b1;
                    bit_tick_reg        <= sub_last;
                    {ext_reg, acc_reg}  <= acc_sum;
                    act_int_reg         <= shadow_int_reg;
                    act_frac_reg        <= shadow_frac_reg;
                    sub_reg             <= sub_last ? '0 : sub_reg + SUB_W'(1);
                end else begin
                    cnt_reg      <= cnt_reg + INT_W'(1);
                    tick_reg     <= 1'b0;
                    bit_tick_reg <= 1'b0;
                end
            end

            assign tick_vec[gi]     = tick_reg;
            assign bit_tick_vec[gi] = bit_tick_reg;
        end
    endgenerate

    assign rx_tick     = tick_vec[0];
    assign rx_bit_tick = bit_tick_vec[0];
    assign tx_tick     = tick_vec[1];
    assign tx_bit_tick = bit_tick_vec[1];

endmodule
